raster_scan_counter: RTL and testbench



---
 rtl/raster_pkg.sv | 31 +++
 rtl/wrap_counter.sv | 40 ++++
 rtl/raster_scan_counter.sv | 89 ++++++++
 tb/tb_raster_scan_counter.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/raster_pkg.sv
// Shared types and parameter legality helpers for the raster scan counter.
// The assert macro is expanded inside a generate scope of the instantiating module.
`ifndef RASTER_PKG_SV
`define RASTER_PKG_SV
`define RASTER_STATIC_ASSERT(cond, msg) \
  if (!(cond)) begin : g_static_assert \
    $error(msg); \
  end
`endif

package raster_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } scan_state_t;

  function automatic bit params_ok(
    input int xb,
    input int yb,
    input int xc,
    input int yc,
    input int ab
  );
    return (xc >= 2) && (xc <= (1 << xb)) &&
           (yc >= 1) && (yc <= (1 << yb)) &&
           (ab >= xb + yb);
  endfunction

endpackage

// File: rtl/wrap_counter.sv
// Up/down counter over 0..COUNT-1 with at-end flag and wrap-to-start load.
// The wrap target is chosen by the caller so serpentine rows can flip direction.
module wrap_counter #(
  parameter int BITS  = 10,
  parameter int COUNT = 100
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            clr_i,
  input  logic            en_i,
  input  logic            down_i,
  input  logic            wrap_hi_i,
  output logic [BITS-1:0] q_o,
  output logic            at_end_o
);

  localparam logic [BITS-1:0] LAST = BITS'(COUNT - 1);

  logic [BITS-1:0] q_q, q_d;

  assign at_end_o = down_i ? (q_q == '0) : (q_q == LAST);
  assign q_o      = q_q;

  always_comb begin
    q_d = q_q;
    if (clr_i) begin
      q_d = '0;
    end else if (en_i) begin
      if (at_end_o)    q_d = wrap_hi_i ? LAST : '0;
      else if (down_i) q_d = q_q - 1'b1;
      else             q_d = q_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) q_q <= '0;
    else       q_q <= q_d;
  end

endmodule

// File: rtl/raster_scan_counter.sv
// 2-D raster scan generator: walks X_COUNT x Y_COUNT cells with stall,
// optional serpentine ordering, linear address and line/frame strobes.
module raster_scan_counter
  import raster_pkg::*;
#(
  parameter int X_BITS     = 10,
  parameter int Y_BITS     = 11,
  parameter int X_COUNT    = 100,
  parameter int Y_COUNT    = 200,
  parameter int SERPENTINE = 0,
  parameter int ADDR_BITS  = X_BITS + Y_BITS
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 hold,
  output logic [X_BITS-1:0]    x,
  output logic [Y_BITS-1:0]    y,
  output logic [ADDR_BITS-1:0] addr,
  output logic                 busy,
  output logic                 line_end,
  output logic                 frame_done
);

  `RASTER_STATIC_ASSERT(params_ok(X_BITS, Y_BITS, X_COUNT, Y_COUNT, ADDR_BITS),
                        "raster_scan_counter: illegal parameters")

  localparam logic [Y_BITS-1:0] Y_LAST = Y_BITS'(Y_COUNT - 1);
  localparam bit                SERP   = (SERPENTINE != 0);

  scan_state_t       state_q, state_d;
  logic [Y_BITS-1:0] y_q, y_d;
  logic              adv, x_end, last, down, wrap_hi;

  assign busy       = (state_q == RUN);
  assign frame_done = (state_q == DONE);
  assign adv        = busy & ~hold;
  // Odd serpentine rows scan right-to-left; the wrap target is the next row's start.
  assign down       = SERP & y_q[0];
  assign wrap_hi    = SERP & ~y_q[0];
  assign last       = (y_q == Y_LAST) & x_end;
  assign line_end   = adv & x_end;

  wrap_counter #(
    .BITS (X_BITS),
    .COUNT(X_COUNT)
  ) u_x (
    .clock    (clock),
    .reset    (reset),
    .clr_i    (adv & last),
    .en_i     (adv),
    .down_i   (down),
    .wrap_hi_i(wrap_hi),
    .q_o      (x),
    .at_end_o (x_end)
  );

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    unique case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN: begin
        if (adv && last) begin
          state_d = DONE;
          y_d     = '0;
        end else if (adv && x_end) begin
          y_d = y_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
    end
  end

  assign y    = y_q;
  assign addr = ADDR_BITS'(y_q) * ADDR_BITS'(X_COUNT) + ADDR_BITS'(x);

endmodule

// File: tb/tb_raster_scan_counter.sv
// Directed bench: 3x2 linear, 3x2 serpentine and default 100x200 scans.
// Expected values are hand-computed constants.
module tb_raster_scan_counter;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // 3x2 linear
  logic       a_rst, a_st, a_hd;
  logic [1:0] a_x;
  logic [0:0] a_y;
  logic [2:0] a_ad;
  logic       a_bz, a_le, a_fd;

  raster_scan_counter #(
    .X_BITS(2), .Y_BITS(1), .X_COUNT(3), .Y_COUNT(2), .SERPENTINE(0)
  ) u_a (
    .clock(clock), .reset(a_rst), .start(a_st), .hold(a_hd),
    .x(a_x), .y(a_y), .addr(a_ad),
    .busy(a_bz), .line_end(a_le), .frame_done(a_fd)
  );

  // 3x2 serpentine
  logic       s_rst, s_st, s_hd;
  logic [1:0] s_x;
  logic [0:0] s_y;
  logic [2:0] s_ad;
  logic       s_bz, s_le, s_fd;

  raster_scan_counter #(
    .X_BITS(2), .Y_BITS(1), .X_COUNT(3), .Y_COUNT(2), .SERPENTINE(1)
  ) u_s (
    .clock(clock), .reset(s_rst), .start(s_st), .hold(s_hd),
    .x(s_x), .y(s_y), .addr(s_ad),
    .busy(s_bz), .line_end(s_le), .frame_done(s_fd)
  );

  // defaults 100x200
  logic        d_rst, d_st, d_hd;
  logic [9:0]  d_x;
  logic [10:0] d_y;
  logic [20:0] d_ad;
  logic        d_bz, d_le, d_fd;

  raster_scan_counter u_d (
    .clock(clock), .reset(d_rst), .start(d_st), .hold(d_hd),
    .x(d_x), .y(d_y), .addr(d_ad),
    .busy(d_bz), .line_end(d_le), .frame_done(d_fd)
  );

  int ax[6] = '{0, 1, 2, 0, 1, 2};
  int ay[6] = '{0, 0, 0, 1, 1, 1};
  int al[6] = '{0, 0, 1, 0, 0, 1};
  int sx[6] = '{0, 1, 2, 2, 1, 0};
  int sa[6] = '{0, 1, 2, 5, 4, 3};

  initial begin
    int n, fds, last_ad, xmax;
    a_rst = 1; a_st = 0; a_hd = 0;
    s_rst = 1; s_st = 0; s_hd = 0;
    d_rst = 1; d_st = 0; d_hd = 0;
    tick(); tick();
    a_rst = 0; s_rst = 0; d_rst = 0;

    // reset state
    chk("rst_busy", a_bz, 0);
    chk("rst_x", a_x, 0);
    chk("rst_y", a_y, 0);
    chk("rst_fd", a_fd, 0);
    chk("rst_le", a_le, 0);

    // 1: linear frame, both DUTs started together
    a_st = 1; s_st = 1;
    a_hd = 1; s_hd = 1;
    tick();
    a_st = 0; s_st = 0;
    a_hd = 0; s_hd = 0;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("lin_busy%0d", i), a_bz, 1);
      chk($sformatf("lin_x%0d", i), a_x, ax[i]);
      chk($sformatf("lin_y%0d", i), a_y, ay[i]);
      chk($sformatf("lin_addr%0d", i), a_ad, i);
      chk($sformatf("lin_le%0d", i), a_le, al[i]);
      chk($sformatf("lin_fd%0d", i), a_fd, 0);
      chk($sformatf("srp_x%0d", i), s_x, sx[i]);
      chk($sformatf("srp_y%0d", i), s_y, ay[i]);
      chk($sformatf("srp_addr%0d", i), s_ad, sa[i]);
      chk($sformatf("srp_le%0d", i), s_le, al[i]);
      tick();
    end
    chk("lin_done_fd", a_fd, 1);
    chk("lin_done_busy", a_bz, 0);
    chk("lin_done_x", a_x, 0);
    chk("lin_done_y", a_y, 0);
    chk("srp_done_fd", s_fd, 1);
    tick();
    chk("lin_fd_pulse", a_fd, 0);
    chk("srp_fd_pulse", s_fd, 0);

    // 3: hold for three cycles at (1,0)
    a_st = 1;
    tick(); n = 1;
    a_st = 0;
    tick(); n++;
    chk("hold_pre_x", a_x, 1);
    a_hd = 1;
    for (int i = 0; i < 3; i++) begin
      chk("hold_x", a_x, 1);
      chk("hold_y", a_y, 0);
      chk("hold_addr", a_ad, 1);
      chk("hold_le", a_le, 0);
      tick(); n++;
    end
    a_hd = 0;
    chk("hold_after_x", a_x, 1);
    tick(); n++;
    chk("hold_resume_x", a_x, 2);
    chk("hold_resume_le", a_le, 1);
    while (!a_fd && n < 50) begin
      tick(); n++;
    end
    chk("hold_fd_latency", n, 10);
    tick();

    // 4: start re-pulsed at (0,1) and during DONE
    a_st = 1;
    tick();
    a_st = 0;
    fds = 0;
    for (int i = 0; i < 20; i++) begin
      a_st = (a_bz && a_x == 0 && a_y == 1) || a_fd;
      if (a_fd) fds++;
      tick();
    end
    a_st = 0;
    chk("restart_fd_count", fds, 1);
    chk("restart_busy", a_bz, 0);

    // 5: reset mid-frame at (1,1)
    a_st = 1;
    tick();
    a_st = 0;
    for (int i = 0; i < 4; i++) tick();
    chk("mid_x", a_x, 1);
    chk("mid_y", a_y, 1);
    a_rst = 1;
    tick();
    a_rst = 0;
    chk("mid_rst_busy", a_bz, 0);
    chk("mid_rst_x", a_x, 0);
    chk("mid_rst_y", a_y, 0);
    chk("mid_rst_fd", a_fd, 0);
    fds = 0;
    for (int i = 0; i < 4; i++) begin
      if (a_fd) fds++;
      tick();
    end
    chk("mid_no_fd", fds, 0);
    a_st = 1;
    tick(); n = 1;
    a_st = 0;
    while (!a_fd && n < 50) begin
      tick(); n++;
    end
    chk("mid_new_frame", n, 7);

    // 6: default 100x200 frame
    d_st = 1;
    tick();
    d_st = 0;
    n = 0; last_ad = -1; xmax = 0;
    while (d_bz && n < 30000) begin
      if (d_x > xmax) xmax = d_x;
      if (d_x == 99 && d_y == 199) last_ad = d_ad;
      tick(); n++;
    end
    chk("def_advances", n, 20000);
    chk("def_last_addr", last_ad, 19999);
    chk("def_xmax", xmax, 99);
    chk("def_fd", d_fd, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
